reorder_buffer_mc: RTL
======================

REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 5; entry count is 2**DEPTH_LOG2.
REQ-002 SHALL have parameter WB_PORTS, default 2; number of writeback channels.
REQ-003 SHALL have parameter COMMIT_W, default 2; maximum commits per cycle, range 1..4.
REQ-004 Port clk_in  in  1  system clock.
REQ-005 Port rst_in  in  1  reset, asynchronous, active-high.
REQ-006 Port rdy_in  in  1  global enable; when low, all state holds.
REQ-007 Port alloc_valid  in  1  allocate one entry at the tail.
REQ-008 Port alloc_type/alloc_rd/alloc_pred  in  2/5/1  entry type (REG, BR, ST, NOP), destination register, predicted-taken bit.
REQ-009 Port alloc_done/alloc_value/alloc_pc  in  1/32/32  entry already complete, its value, and its redirect address.
REQ-010 Port alloc_ready/alloc_id  out  1/DEPTH_LOG2  entry free; tail index.
REQ-011 Port wb_valid/wb_id/wb_value  in  WB_PORTS/WB_PORTS*DEPTH_LOG2/WB_PORTS*32  packed writeback channels.
REQ-012 Port qry_id/qry_ready/qry_value  in/out/out  2*DEPTH_LOG2/2/64  two operand lookups.
REQ-013 Port commit_valid/commit_type/commit_rd/commit_value  out  COMMIT_W/2*COMMIT_W/5*COMMIT_W/32*COMMIT_W  slot k carries the k-th oldest entry.
REQ-014 Port head_id/flush/flush_pc  out  DEPTH_LOG2/1/32  head index; registered flush pulse; redirect address.

Function
- REQ-015 SHALL hold head, tail and count (DEPTH_LOG2+1 bits); head and tail wrap modulo 2**DEPTH_LOG2.
- REQ-016 alloc_ready SHALL be high only when count < 2**DEPTH_LOG2 and flush is low; it SHALL be combinational on registered state only.
- REQ-017 An allocation SHALL occur when alloc_valid && alloc_ready; the entry is written at tail, and tail advances next edge.
- REQ-018 A writeback SHALL set done and store the value for wb_id; on a same-id conflict, the highest channel index wins.
- REQ-019 Commit slot k SHALL be valid iff count > k, entries head..head+k are all done, and no earlier slot this cycle is a mispredicted BR.
- REQ-020 A BR entry SHALL be mispredicted when value bit0 != its pred bit; on commit it sets flush=1 and flush_pc=its pc on the next edge.
- REQ-021 Commit outputs SHALL be combinational; head advances by the number of valid slots; count is updated by allocations minus commits.
- REQ-022 In a cycle with flush=1, the block SHALL ignore alloc and wb; next edge: head=tail=count=0, all done bits cleared, flush=0.
- REQ-023 Full + simultaneous commit: allocation SHALL still be refused that cycle (no same-cycle reuse).
- REQ-024 Empty: all commit_valid SHALL be 0; qry of an unallocated entry SHALL return ready=0.
- REQ-025 rdy_in low SHALL gate all state updates and force commit_valid to 0.

Reset
- REQ-026 On rst_in: head=tail=count=0, flush=0, flush_pc=0, all done bits=0, all stored values=0; alloc_ready is 1 after release.
- REQ-027 Reset asserted mid-operation SHALL abort any pending flush and drop all entries immediately.

Configuration
- REQ-028 With ROB_BYPASS_EN defined, qry_ready/qry_value SHALL forward same-cycle wb data (highest channel index wins), then same-cycle alloc_done data, then stored data.
- REQ-029 Without ROB_BYPASS_EN, queries SHALL reflect registered state only, with one cycle extra latency.

Structure
- REQ-030 A shared package SHALL hold the type encodings (REG=0, BR=1, ST=2, NOP=3) and the default DEPTH_LOG2.
- REQ-031 Commit-slot readiness SHALL be a sub-module rob_commit_sel (done vector, head, count -> slot valids).

Verification
- REQ-032 Directed scenarios:
  - Allocate 32 entries -> alloc_ready=0 at count 32; the 33rd alloc_valid is ignored; tail wraps to 0.
  - Allocate REG ids 0,1; write back both channels in one cycle (values 5, 7) -> next cycle both commit_valid slots high, rd/value correct, count=0.
  - Write back id 1 before id 0 -> no commit until id 0 is done, then both commit in the same cycle.
  - BR with pred=1 written back with value 0, followed by a done REG -> only slot 0 commits; flush=1 with flush_pc set; next cycle count=0.
  - Writeback of value 9 to id 3 while qry_id=3: with ROB_BYPASS_EN, qry_ready=1 and value=9 in the same cycle; without it, one cycle later.
  - Assert rst_in while flush is pending -> flush=0 and count=0 immediately.

Source files
------------

// File: rtl/reorder_buffer_mc_pkg.sv
// Shared definitions for the reorder buffer slice.
//   rob_type_e         : entry type encoding (REG=0, BR=1, ST=2, NOP=3)
//   ROB_DEPTH_LOG2_DEF : default log2 of the entry count
//   rob_mispredict     : branch outcome bit0 disagrees with the predicted-taken bit
package reorder_buffer_mc_pkg;

   typedef enum logic [1:0] {
      ROB_REG = 2'd0,
      ROB_BR  = 2'd1,
      ROB_ST  = 2'd2,
      ROB_NOP = 2'd3
   } rob_type_e;

   localparam int ROB_DEPTH_LOG2_DEF = 5;

   function automatic logic rob_mispredict(rob_type_e t, logic [31:0] v, logic pred);
      return (t == ROB_BR) && (v[0] != pred);
   endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit-slot readiness: slot k is ready when the ROB holds more than k
// entries and every entry from head to head+k is done.
//   done       : per-entry done bits
//   head       : current head index
//   count      : number of occupied entries
//   slot_valid : per-slot readiness (a prefix of ones)
module rob_commit_sel
   import reorder_buffer_mc_pkg::*;
#(
   parameter int DEPTH_LOG2 = ROB_DEPTH_LOG2_DEF,
   parameter int COMMIT_W   = 2
) (
   input  logic [(1<<DEPTH_LOG2)-1:0] done,
   input  logic [DEPTH_LOG2-1:0]      head,
   input  logic [DEPTH_LOG2:0]        count,
   output logic [COMMIT_W-1:0]        slot_valid
);

   always_comb begin
      logic                  chain;
      logic [DEPTH_LOG2-1:0] pos;
      chain      = 1'b1;
      pos        = head;
      slot_valid = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         pos           = head + DEPTH_LOG2'(k);
         chain         = chain && done[pos] && (count > (DEPTH_LOG2+1)'(k));
         slot_valid[k] = chain;
      end
   end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order allocation at the tail, out-of-order
// writeback over WB_PORTS channels, up to COMMIT_W in-order commits per cycle,
// and a registered flush on a committed mispredicted branch.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   alloc_*   : allocation request; alloc_ready/alloc_id report space and tail
//   wb_*      : packed writeback channels (highest channel wins on same id)
//   qry_*     : two operand lookups
//   commit_*  : combinational commit slots, slot k = k-th oldest entry
//   head_id, flush, flush_pc : head index, registered flush pulse, redirect
// Build option: ROB_BYPASS_EN forwards same-cycle writeback / allocation data
// onto the query outputs; without it queries read registered state only.
module reorder_buffer_mc
   import reorder_buffer_mc_pkg::*;
#(
   parameter int DEPTH_LOG2 = ROB_DEPTH_LOG2_DEF,
   parameter int WB_PORTS   = 2,
   parameter int COMMIT_W   = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           rdy_in,
   input  logic                           alloc_valid,
   input  logic [1:0]                     alloc_type,
   input  logic [4:0]                     alloc_rd,
   input  logic                           alloc_pred,
   input  logic                           alloc_done,
   input  logic [31:0]                    alloc_value,
   input  logic [31:0]                    alloc_pc,
   output logic                           alloc_ready,
   output logic [DEPTH_LOG2-1:0]          alloc_id,
   input  logic [WB_PORTS-1:0]            wb_valid,
   input  logic [WB_PORTS*DEPTH_LOG2-1:0] wb_id,
   input  logic [WB_PORTS*32-1:0]         wb_value,
   input  logic [2*DEPTH_LOG2-1:0]        qry_id,
   output logic [1:0]                     qry_ready,
   output logic [63:0]                    qry_value,
   output logic [COMMIT_W-1:0]            commit_valid,
   output logic [2*COMMIT_W-1:0]          commit_type,
   output logic [5*COMMIT_W-1:0]          commit_rd,
   output logic [32*COMMIT_W-1:0]         commit_value,
   output logic [DEPTH_LOG2-1:0]          head_id,
   output logic                           flush,
   output logic [31:0]                    flush_pc
);

   localparam int                    DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   ONE_CNT   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] ONE_ID    = DEPTH_LOG2'(1);

   logic [DEPTH_LOG2-1:0] head_q, tail_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic [DEPTH-1:0]      done_q;
   logic [DEPTH-1:0]      pred_q;
   rob_type_e             type_q  [DEPTH];
   logic [4:0]            rd_q    [DEPTH];
   logic [31:0]           value_q [DEPTH];
   logic [31:0]           pc_q    [DEPTH];

   logic                  upd_en;
   logic                  alloc_fire;
   logic [WB_PORTS-1:0]   wb_fire;
   logic [COMMIT_W-1:0]   sel_valid;
   logic [DEPTH_LOG2:0]   n_commit;
   logic                  mispredict_fire;
   logic [31:0]           mispredict_pc;

   // alloc_ready looks only at registered state so it cannot loop back
   // through a requester that waits on it.
   assign alloc_ready = (count_q < DEPTH_CNT) && !flush;
   assign alloc_id    = tail_q;
   assign head_id     = head_q;
   assign upd_en      = rdy_in && !flush;
   assign alloc_fire  = alloc_valid && alloc_ready && rdy_in;
   assign wb_fire     = wb_valid & {WB_PORTS{upd_en}};

   rob_commit_sel #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .COMMIT_W   (COMMIT_W)
   ) u_commit_sel (
      .done       (done_q),
      .head       (head_q),
      .count      (count_q),
      .slot_valid (sel_valid)
   );

   // A committing mispredicted branch stops all younger slots this cycle.
   always_comb begin
      logic                  blocked;
      logic [DEPTH_LOG2-1:0] cidx;
      blocked         = !upd_en;
      cidx            = head_q;
      n_commit        = '0;
      mispredict_fire = 1'b0;
      mispredict_pc   = '0;
      commit_valid    = '0;
      commit_type     = '0;
      commit_rd       = '0;
      commit_value    = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         cidx                     = head_q + DEPTH_LOG2'(k);
         commit_type[2*k +: 2]    = type_q[cidx];
         commit_rd[5*k +: 5]      = rd_q[cidx];
         commit_value[32*k +: 32] = value_q[cidx];
         if (sel_valid[k] && !blocked) begin
            commit_valid[k] = 1'b1;
            n_commit        = n_commit + ONE_CNT;
            if (rob_mispredict(type_q[cidx], value_q[cidx], pred_q[cidx])) begin
               blocked         = 1'b1;
               mispredict_fire = 1'b1;
               mispredict_pc   = pc_q[cidx];
            end
         end
      end
   end

   // Entry is live when its distance from head is below count.
   always_comb begin
      logic [DEPTH_LOG2-1:0] qid;
      logic [DEPTH_LOG2-1:0] offs;
      qid       = '0;
      offs      = '0;
      qry_ready = '0;
      qry_value = '0;
      for (int q = 0; q < 2; q++) begin
         qid                   = qry_id[q*DEPTH_LOG2 +: DEPTH_LOG2];
         offs                  = qid - head_q;
         qry_ready[q]          = done_q[qid] && ({1'b0, offs} < count_q);
         qry_value[32*q +: 32] = value_q[qid];
`ifdef ROB_BYPASS_EN
         if (alloc_fire && alloc_done && (tail_q == qid)) begin
            qry_ready[q]          = 1'b1;
            qry_value[32*q +: 32] = alloc_value;
         end
         for (int c = 0; c < WB_PORTS; c++) begin
            if (wb_fire[c] && (wb_id[c*DEPTH_LOG2 +: DEPTH_LOG2] == qid)) begin
               qry_ready[q]          = 1'b1;
               qry_value[32*q +: 32] = wb_value[c*32 +: 32];
            end
         end
`endif
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         done_q   <= '0;
         pred_q   <= '0;
         flush    <= 1'b0;
         flush_pc <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            type_q[i]  <= ROB_REG;
            rd_q[i]    <= '0;
            value_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (rdy_in) begin
         if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
            flush   <= 1'b0;
         end else begin
            if (alloc_fire) begin
               type_q[tail_q]  <= rob_type_e'(alloc_type);
               rd_q[tail_q]    <= alloc_rd;
               pred_q[tail_q]  <= alloc_pred;
               done_q[tail_q]  <= alloc_done;
               value_q[tail_q] <= alloc_value;
               pc_q[tail_q]    <= alloc_pc;
               tail_q          <= tail_q + ONE_ID;
            end
            // Ascending loop: the last (highest) channel's write lands.
            for (int c = 0; c < WB_PORTS; c++) begin
               if (wb_fire[c]) begin
                  done_q[wb_id[c*DEPTH_LOG2 +: DEPTH_LOG2]]  <= 1'b1;
                  value_q[wb_id[c*DEPTH_LOG2 +: DEPTH_LOG2]] <= wb_value[c*32 +: 32];
               end
            end
            head_q  <= head_q + n_commit[DEPTH_LOG2-1:0];
            count_q <= count_q + {{DEPTH_LOG2{1'b0}}, alloc_fire} - n_commit;
            flush   <= mispredict_fire;
            if (mispredict_fire) begin
               flush_pc <= mispredict_pc;
            end
         end
      end
   end

endmodule
